// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a 2-entry skid buffer, flush, bubble insertion
// and saturating stall/flush counters. in_ready depends only on registered state.
module pipe_stage_skid #(
  parameter int CTRL_W = 12,
  parameter int DATA_W = 271,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              bubble,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic [CTRL_W-1:0] beat_ctrl;
  logic [DATA_W-1:0] beat_data;
  logic              push, pop;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    push        = in_valid && in_ready;
    pop         = out_valid && out_ready;
    beat_ctrl   = bubble ? '0 : in_ctrl;
    beat_data   = bubble ? '0 : in_data;

    // Empty entries are kept at zero so the outputs read zero when out_valid=0.
    if (flush) begin
      state_d     = EMPTY;
      main_ctrl_d = '0;
      main_data_d = '0;
      skid_ctrl_d = '0;
      skid_data_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            main_ctrl_d = beat_ctrl;
            main_data_d = beat_data;
            state_d     = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_ctrl_d = beat_ctrl;
            main_data_d = beat_data;
          end else if (push) begin
            skid_ctrl_d = beat_ctrl;
            skid_data_d = beat_data;
            state_d     = TWO;
          end else if (pop) begin
            main_ctrl_d = '0;
            main_data_d = '0;
            state_d     = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = '0;
            skid_data_d = '0;
            state_d     = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (in_valid && !in_ready && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && (flush_cnt_q != '1))                 flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule
